jhash_core: RTL and testbench

Consumer end of the jhash block stream. Accepts 3×32-bit blocks (stream_data0..2) under the stream_valid/stream_ack handshake and runs the Bob Jenkins lookup2 word hash (jhash2 semantics) over them. It finalises on the block flagged stream_done and presents a 32-bit hash to the output stage under a valid/ack handshake. It sits directly after the word-assembly front end in the jhash datapath.

---
 rtl/jhash_core.sv | 144 ++++++++++++++
 tb/tb_jhash_core.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/jhash_core.sv
// jhash_core: lookup2 (jhash2) word hash over 3x32-bit blocks.
// Runs one mix sub-step per cycle and holds the hash under a valid/ack handshake.
module jhash_core (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce,
    input  logic [31:0] initval,
    input  logic [31:0] stream_data0,
    input  logic [31:0] stream_data1,
    input  logic [31:0] stream_data2,
    input  logic        stream_valid,
    input  logic        stream_done,
    input  logic [1:0]  stream_left,
    output logic        stream_ack,
    output logic [31:0] hash_out,
    output logic        hash_valid,
    input  logic        hash_ack,
    output logic        busy
);
    localparam logic [31:0] GOLDEN = 32'h9e3779b9;

    typedef enum logic [2:0] {WAIT, MIX, FADD, FMIX, DONE} state_t;

    state_t      state;
    logic [31:0] a, b, c;
    logic [31:0] word_cnt;
    logic        first;
    logic        last;
    logic [3:0]  step;

    logic [31:0] base_a, base_b, base_c;
    logic [31:0] mix_a, mix_b, mix_c;
    logic [31:0] tail_len;

    assign stream_ack = (state == WAIT) & stream_valid & ce & ~rst;

    always_comb begin
        base_a = first ? GOLDEN  : a;
        base_b = first ? GOLDEN  : b;
        base_c = first ? initval : c;
    end

    // Total message length in words when the final block carries a tail.
    always_comb begin
        case (stream_left)
            2'b01:   tail_len = word_cnt + 32'd1;
            2'b10:   tail_len = word_cnt + 32'd2;
            default: tail_len = word_cnt;
        endcase
    end

    always_comb begin
        mix_a = a;
        mix_b = b;
        mix_c = c;
        case (step)
            4'd0:    mix_a = (a - b - c) ^ (c >> 13);
            4'd1:    mix_b = (b - c - a) ^ (a << 8);
            4'd2:    mix_c = (c - a - b) ^ (b >> 13);
            4'd3:    mix_a = (a - b - c) ^ (c >> 12);
            4'd4:    mix_b = (b - c - a) ^ (a << 16);
            4'd5:    mix_c = (c - a - b) ^ (b >> 5);
            4'd6:    mix_a = (a - b - c) ^ (c >> 3);
            4'd7:    mix_b = (b - c - a) ^ (a << 10);
            4'd8:    mix_c = (c - a - b) ^ (b >> 15);
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= WAIT;
            a          <= '0;
            b          <= '0;
            c          <= '0;
            word_cnt   <= '0;
            first      <= 1'b1;
            last       <= 1'b0;
            step       <= '0;
            hash_out   <= '0;
            hash_valid <= 1'b0;
            busy       <= 1'b0;
        end else begin
            case (state)
                WAIT: begin
                    if (stream_ack) begin
                        busy  <= 1'b1;
                        first <= 1'b0;
                        step  <= '0;
                        if (!stream_done || stream_left == 2'b00) begin
                            a        <= base_a + stream_data0;
                            b        <= base_b + stream_data1;
                            c        <= base_c + stream_data2;
                            word_cnt <= word_cnt + 32'd3;
                            last     <= stream_done;
                            state    <= MIX;
                        end else begin
                            // Tail block folds the length add in directly and skips FADD.
                            a        <= (stream_left != 2'b11) ? base_a + stream_data0 : base_a;
                            b        <= (stream_left == 2'b10) ? base_b + stream_data1 : base_b;
                            c        <= base_c + {tail_len[29:0], 2'b00};
                            word_cnt <= tail_len;
                            state    <= FMIX;
                        end
                    end
                end
                MIX, FMIX: begin
                    a <= mix_a;
                    b <= mix_b;
                    c <= mix_c;
                    if (step == 4'd8) begin
                        step <= '0;
                        if (state == FMIX) begin
                            hash_out   <= mix_c;
                            hash_valid <= 1'b1;
                            state      <= DONE;
                        end else if (last) begin
                            state <= FADD;
                        end else begin
                            state <= WAIT;
                        end
                    end else begin
                        step <= step + 4'd1;
                    end
                end
                FADD: begin
                    c     <= c + {word_cnt[29:0], 2'b00};
                    state <= FMIX;
                end
                DONE: begin
                    if (hash_ack) begin
                        hash_valid <= 1'b0;
                        first      <= 1'b1;
                        word_cnt   <= '0;
                        last       <= 1'b0;
                        busy       <= 1'b0;
                        state      <= WAIT;
                    end
                end
                default: state <= WAIT;
            endcase
        end
    end
endmodule

// File: tb/tb_jhash_core.sv
// tb_jhash_core: directed messages checked against a software lookup2 jhash2 model.
module tb_jhash_core;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ce = 1'b1;
    logic [31:0] initval = '0;
    logic [31:0] stream_data0 = '0;
    logic [31:0] stream_data1 = '0;
    logic [31:0] stream_data2 = '0;
    logic        stream_valid = 1'b0;
    logic        stream_done = 1'b0;
    logic [1:0]  stream_left = 2'b00;
    logic        stream_ack;
    logic [31:0] hash_out;
    logic        hash_valid;
    logic        hash_ack = 1'b0;
    logic        busy;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int ack_cnt = 0;
    int prev_acc = 0;
    int last_acc = 0;
    logic [31:0] msg [0:7];

    jhash_core dut (
        .clk(clk), .rst(rst), .ce(ce), .initval(initval),
        .stream_data0(stream_data0), .stream_data1(stream_data1), .stream_data2(stream_data2),
        .stream_valid(stream_valid), .stream_done(stream_done), .stream_left(stream_left),
        .stream_ack(stream_ack), .hash_out(hash_out), .hash_valid(hash_valid),
        .hash_ack(hash_ack), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (stream_ack) ack_cnt <= ack_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic ref_mix(inout logic [31:0] a, inout logic [31:0] b, inout logic [31:0] c);
        a -= b; a -= c; a ^= (c >> 13);
        b -= c; b -= a; b ^= (a << 8);
        c -= a; c -= b; c ^= (b >> 13);
        a -= b; a -= c; a ^= (c >> 12);
        b -= c; b -= a; b ^= (a << 16);
        c -= a; c -= b; c ^= (b >> 5);
        a -= b; a -= c; a ^= (c >> 3);
        b -= c; b -= a; b ^= (a << 10);
        c -= a; c -= b; c ^= (b >> 15);
    endtask

    task automatic ref_hash(input int len, input logic [31:0] iv, output logic [31:0] h);
        logic [31:0] a, b, c;
        int rem, k;
        a = 32'h9e3779b9; b = 32'h9e3779b9; c = iv;
        rem = len; k = 0;
        while (rem >= 3) begin
            a += msg[k]; b += msg[k+1]; c += msg[k+2];
            ref_mix(a, b, c);
            k += 3; rem -= 3;
        end
        c += 32'(len * 4);
        if (rem == 2) b += msg[k+1];
        if (rem >= 1) a += msg[k];
        ref_mix(a, b, c);
        h = c;
    endtask

    task automatic fill_garbage();
        for (int i = 0; i < 8; i++) msg[i] = 32'hdeadc0de ^ (32'(i) * 32'h01010101);
    endtask

    task automatic wait_accept();
        logic ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (stream_ack) begin
                @(posedge clk); #1;
                ok = 1'b1;
                break;
            end
        end
        prev_acc = last_acc;
        last_acc = cyc;
        check("accept_seen", {31'b0, ok}, 32'd1);
    endtask

    task automatic send_block(input logic [31:0] k0, input logic [31:0] k1, input logic [31:0] k2,
                              input logic done, input logic [1:0] left);
        stream_data0 = k0; stream_data1 = k1; stream_data2 = k2;
        stream_done = done; stream_left = left; stream_valid = 1'b1;
        wait_accept();
        stream_valid = 1'b0; stream_done = 1'b1; stream_left = 2'b11;
        stream_data0 = 32'h5a5a5a5a; stream_data1 = 32'ha5a5a5a5; stream_data2 = 32'h3c3c3c3c;
    endtask

    task automatic wait_hash(input string tag, input logic [31:0] exp_h, input int exp_lat);
        logic ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (hash_valid) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        check({tag, "_valid"}, {31'b0, ok}, 32'd1);
        check({tag, "_hash"}, hash_out, exp_h);
        check({tag, "_latency"}, 32'(cyc - last_acc + 1), 32'(exp_lat));
        check({tag, "_busy"}, {31'b0, busy}, 32'd1);
    endtask

    task automatic ack_hash(input string tag, input int delay);
        repeat (delay) begin @(posedge clk); #1; end
        check({tag, "_held"}, {31'b0, hash_valid}, 32'd1);
        hash_ack = 1'b1;
        @(posedge clk); #1;
        hash_ack = 1'b0;
        check({tag, "_valid_clr"}, {31'b0, hash_valid}, 32'd0);
        check({tag, "_busy_clr"}, {31'b0, busy}, 32'd0);
    endtask

    task automatic run_msg(input string tag, input int len, input logic [31:0] iv, input int exp_lat);
        logic [31:0] exp_h;
        int rem, idx;
        ref_hash(len, iv, exp_h);
        initval = iv;
        rem = len; idx = 0;
        forever begin
            if (rem > 3) begin
                send_block(msg[idx], msg[idx+1], msg[idx+2], 1'b0, 2'b00);
                rem -= 3; idx += 3;
            end else begin
                send_block(msg[idx], msg[idx+1], msg[idx+2], 1'b1,
                           (rem == 3) ? 2'b00 : (rem == 0) ? 2'b11 : 2'(rem));
                break;
            end
            // The seed must only matter on the first accept.
            initval = ~iv;
        end
        initval = ~iv;
        wait_hash(tag, exp_h, exp_lat);
        ack_hash(tag, 2);
    endtask

    initial begin
        logic [31:0] exp_a, exp_b;
        int acks0, t_ce;

        stream_valid = 1'b1;
        #12;
        check("rst_ack", {31'b0, stream_ack}, 32'd0);
        check("rst_hash_out", hash_out, 32'd0);
        check("rst_hash_valid", {31'b0, hash_valid}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        stream_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        fill_garbage();
        run_msg("empty", 0, 32'h0, 10);

        fill_garbage();
        msg[0] = 32'd1; msg[1] = 32'd2; msg[2] = 32'd3;
        run_msg("three", 3, 32'h0, 20);

        fill_garbage();
        msg[0] = 32'h11111111; msg[1] = 32'h22222222; msg[2] = 32'h33333333;
        msg[3] = 32'h44444444; msg[4] = 32'h55555555;
        acks0 = ack_cnt;
        run_msg("five", 5, 32'hdeadbeef, 10);
        check("five_acks", 32'(ack_cnt - acks0), 32'd2);
        check("five_spacing", 32'(last_acc - prev_acc), 32'd10);

        fill_garbage();
        for (int i = 0; i < 6; i++) msg[i] = 32'h01000000 * 32'(i + 1) + 32'h0000abcd;
        run_msg("six", 6, 32'h00000001, 20);

        fill_garbage();
        msg[0] = 32'hfedcba98; msg[1] = 32'h76543210; msg[2] = 32'h0f0f0f0f; msg[3] = 32'hf0f0f0f0;
        run_msg("four", 4, 32'h00000055, 10);

        // Back-to-back: valid stays high across the DONE hold.
        fill_garbage();
        msg[0] = 32'h01234567;
        ref_hash(1, 32'h1234, exp_a);
        msg[0] = 32'hcafebabe; msg[1] = 32'h12345678;
        ref_hash(2, 32'h1234, exp_b);
        initval = 32'h1234;
        stream_data0 = 32'h01234567; stream_data1 = 32'h99999999; stream_data2 = 32'h88888888;
        stream_done = 1'b1; stream_left = 2'b01; stream_valid = 1'b1;
        wait_accept();
        stream_data0 = 32'hcafebabe; stream_data1 = 32'h12345678; stream_left = 2'b10;
        acks0 = ack_cnt;
        wait_hash("b2b_a", exp_a, 10);
        repeat (7) begin @(posedge clk); #1; end
        check("b2b_no_ack_in_done", 32'(ack_cnt - acks0), 32'd0);
        hash_ack = 1'b1;
        @(posedge clk); #1;
        hash_ack = 1'b0;
        @(negedge clk);
        check("b2b_ack_after_hash_ack", {31'b0, stream_ack}, 32'd1);
        @(posedge clk); #1;
        last_acc = cyc;
        stream_valid = 1'b0;
        wait_hash("b2b_b", exp_b, 10);
        ack_hash("b2b_b", 0);

        // ce low holds off acceptance only.
        fill_garbage();
        msg[0] = 32'd7; msg[1] = 32'd8; msg[2] = 32'd9;
        ref_hash(3, 32'h77, exp_a);
        initval = 32'h77;
        ce = 1'b0;
        stream_data0 = 32'd7; stream_data1 = 32'd8; stream_data2 = 32'd9;
        stream_done = 1'b1; stream_left = 2'b00; stream_valid = 1'b1;
        acks0 = ack_cnt;
        repeat (15) begin @(posedge clk); #1; end
        check("ce_no_ack", 32'(ack_cnt - acks0), 32'd0);
        ce = 1'b1;
        t_ce = cyc;
        send_block(32'd7, 32'd8, 32'd9, 1'b1, 2'b00);
        check("ce_first_edge", 32'(last_acc - t_ce), 32'd1);
        wait_hash("ce", exp_a, 20);
        ack_hash("ce", 1);

        // Async reset in the middle of MIX (step counter at 4).
        fill_garbage();
        initval = 32'h0badf00d;
        send_block(32'h10203040, 32'h50607080, 32'h90a0b0c0, 1'b0, 2'b00);
        repeat (4) begin @(posedge clk); #1; end
        check("mid_busy", {31'b0, busy}, 32'd1);
        stream_valid = 1'b1;
        #2 rst = 1'b1;
        #1;
        check("mid_rst_ack", {31'b0, stream_ack}, 32'd0);
        check("mid_rst_busy", {31'b0, busy}, 32'd0);
        check("mid_rst_hash_out", hash_out, 32'd0);
        check("mid_rst_hash_valid", {31'b0, hash_valid}, 32'd0);
        stream_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        fill_garbage();
        msg[0] = 32'hcafebabe;
        run_msg("post_rst", 1, 32'h0badf00d, 10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
